wb_write_arbiter: RTL and testbench
===================================

# wb_write_arbiter

Write-side initiator for the 32-entry, two-read/one-write register file: it owns the single write port (`we`, `waddr`, `wdata`) and merges two writeback sources onto it. The in-order pipeline writeback always has priority. Long-latency results (multiply/divide, late loads) arrive through a valid/ready handshake, wait in a small FIFO, and drain into idle write-port cycles. The block also reports which registers still have pending long-latency writes, so decode can stall on them.

## Interface
- `ADDR_W`, default 5: register address width; matches the register file's address bus.
- `DATA_W`, default 32: register data width.
- `DEPTH`, default 4: long-latency FIFO entries; power of two, 2..16.
- `CNT_W`, default 3: width of `fifo_count`; equals log2(`DEPTH`)+1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pipe_we`  in  1  pipeline writeback valid; never back-pressured.
- `pipe_waddr`  in  `ADDR_W`  pipeline destination register.
- `pipe_wdata`  in  `DATA_W`  pipeline result.
- `lsrc_valid`  in  1  long-latency result offered.
- `lsrc_ready`  out  1  long-latency result accepted when `lsrc_valid` and `lsrc_ready` are both 1.
- `lsrc_waddr`  in  `ADDR_W`  long-latency destination register.
- `lsrc_wdata`  in  `DATA_W`  long-latency result.
- `chk_addr1`, `chk_addr2`  in  `ADDR_W`  decode read-port addresses to test.
- `chk_busy1`, `chk_busy2`  out  1  a pending FIFO write targets `chk_addrN`.
- `we`  out  1  register-file write enable; registered.
- `waddr`  out  `ADDR_W`  register-file write address; registered.
- `wdata`  out  `DATA_W`  register-file write data; registered.
- `fifo_count`  out  `CNT_W`  number of valid FIFO entries.

## Operation
- **Reset values**, applied at the first edge with `rst`=1:
  - `we`=0, `waddr`=0, `wdata`=0.
  - `fifo_count`=0; FIFO pointers 0.
  - `lsrc_ready`=0 while `rst` is high.
- **Reset mid-operation** flushes all pending FIFO entries; they are lost and never written.
- **Output register update**, every non-reset edge, in priority order:
  1. `pipe_we`=1 and `pipe_waddr`≠0: load the pipeline write.
  2. Otherwise, FIFO non-empty: pop the head and load it.
  3. Otherwise: `we`=0, and `waddr`/`wdata` hold their previous values.
- **Pipeline writes to register 0** produce no write (`we`=0). They do not block a FIFO pop in that cycle.
- **Long-latency writes to register 0** are accepted but discarded: not pushed, and `fifo_count` is unchanged.
- **`lsrc_ready` rule:** `lsrc_ready` = !`rst` && (`fifo_count` ≠ `DEPTH`).
  - It is combinational from the count only.
  - A full FIFO refuses a new entry even in a cycle where it also pops.
- **Simultaneous push and pop** in one cycle: `fifo_count` is unchanged. Pointers wrap modulo `DEPTH`.
- **Ordering:**
  - FIFO entries drain strictly in acceptance order.
  - Decode must not issue a pipeline write to a register whose `chk_busy` is 1. This WAW rule is an upstream obligation; the bench asserts it.
- **Busy lookup:** `chk_busyN` is combinational, 1 iff some valid FIFO entry's address equals `chk_addrN`.
  - `chk_addrN`=0 always gives 0.
  - The registered output stage is not reported as busy. The register file forwards its write port to reads in the same cycle.

## Timing
- **Pipeline path:** `pipe_we` at cycle N → `we`=1 with that address and data during N+1. The register file commits at the end of N+1. Latency is 1 cycle.
- **Long-latency path:**
  - Accept at N → entry visible in FIFO and `chk_busy` at N+1.
  - Earliest `we` at N+2, if `pipe_we`=0 at N+1. The minimum latency is 2 cycles.
  - Each cycle with a valid pipeline write delays the FIFO drain by one cycle.
- **Throughput:** at most one write-port update per cycle; at most one FIFO push per cycle.
- **Starvation:** continuous valid pipeline writes starve the FIFO indefinitely. While full, the FIFO back-pressures through `lsrc_ready`=0.

## Configuration
- **`WB_BYPASS_EN` defined:** a long-latency entry skips the FIFO and loads the output register directly at that edge (latency 1) when all of these hold in cycle N:
  - it is accepted with a non-zero address;
  - the FIFO is empty;
  - `pipe_we`&&`pipe_waddr`≠0 is false.

  It is never pushed and never reported busy.
- **Not defined:** every long-latency entry goes through the FIFO, with a minimum latency of 2.

## Test plan
- **Reset:** hold `rst` 3 cycles while pulsing `pipe_we` and `lsrc_valid` → `we`=0, `waddr`=0, `wdata`=0, `fifo_count`=0, `lsrc_ready`=0 throughout; `lsrc_ready`=1 in the first cycle after release.
- **Pipeline write:** `pipe_we`=1, addr 5, data 0xDEADBEEF at N → `we`=1, `waddr`=5, `wdata`=0xDEADBEEF at N+1.
- **Register-0 pipeline write:** `pipe_we`=1 with addr 0 at N → `we`=0 at N+1.
- **Long-latency write, no bypass:** lsrc addr 7, data 0x12345678 at N with the pipeline idle → `chk_busy1`=1 for `chk_addr1`=7 at N+1; `we`=1 addr 7 at N+2; `chk_busy1`=0 at N+2.
  - With `WB_BYPASS_EN` → `we`=1 at N+1, `chk_busy1` never 1.
- **Fill and back-pressure:** with continuous `pipe_we` (addrs 1..8), push lsrc addrs 9,10,11,12 → `fifo_count`=4, `lsrc_ready`=0, and a 5th offer is held. Drop `pipe_we` → `we` addrs 9,10,11,12 on four consecutive cycles; the held 5th entry is accepted in the cycle after the first pop.
- **Reset mid-drain:** 3 entries queued, assert `rst` 1 cycle → `fifo_count`=0, no `we` for the flushed entries, `chk_busy`=0.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, and long-latency results queue in a FIFO that drains into idle cycles.
// Optional macro WB_BYPASS_EN lets a long-latency result skip an empty FIFO when the write port is free.
module wb_write_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pipe_we,
   input  logic [ADDR_W-1:0] pipe_waddr,
   input  logic [DATA_W-1:0] pipe_wdata,
   input  logic              lsrc_valid,
   output logic              lsrc_ready,
   input  logic [ADDR_W-1:0] lsrc_waddr,
   input  logic [DATA_W-1:0] lsrc_wdata,
   input  logic [ADDR_W-1:0] chk_addr1,
   input  logic [ADDR_W-1:0] chk_addr2,
   output logic              chk_busy1,
   output logic              chk_busy2,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   output logic [CNT_W-1:0]  fifo_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
   logic [DATA_W-1:0] fifo_data_q [DEPTH];
   logic [DEPTH-1:0]  vld_q, vld_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic pipe_fire, full, empty, accept, bypass, push, pop;

   assign pipe_fire  = pipe_we && (pipe_waddr != '0);
   assign full       = (count_q == CNT_W'(DEPTH));
   assign empty      = (count_q == '0);
   assign lsrc_ready = !rst && !full;
   // Register-0 results are handshaken but never stored.
   assign accept     = lsrc_valid && lsrc_ready && (lsrc_waddr != '0);
   assign pop        = !pipe_fire && !empty;
`ifdef WB_BYPASS_EN
   assign bypass     = accept && empty && !pipe_fire;
`else
   assign bypass     = 1'b0;
`endif
   assign push       = accept && !bypass;

   always_comb begin
      we_d     = 1'b0;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      vld_d    = vld_q;
      if (pipe_fire) begin
         we_d    = 1'b1;
         waddr_d = pipe_waddr;
         wdata_d = pipe_wdata;
      end else if (pop) begin
         we_d    = 1'b1;
         waddr_d = fifo_addr_q[rd_ptr_q];
         wdata_d = fifo_data_q[rd_ptr_q];
      end else if (bypass) begin
         we_d    = 1'b1;
         waddr_d = lsrc_waddr;
         wdata_d = lsrc_wdata;
      end
      // Push and pop never share a slot: push needs not-full, pop needs not-empty.
      if (push) begin
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         vld_d[wr_ptr_q] = 1'b1;
      end
      if (pop) begin
         rd_ptr_d        = rd_ptr_q + PTR_W'(1);
         vld_d[rd_ptr_q] = 1'b0;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         vld_q    <= '0;
         count_q  <= '0;
      end else begin
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         vld_q    <= vld_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= lsrc_waddr;
         fifo_data_q[wr_ptr_q] <= lsrc_wdata;
      end
   end

   // The output register is deliberately excluded: the register file forwards its write port.
   always_comb begin
      chk_busy1 = 1'b0;
      chk_busy2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && (fifo_addr_q[i] == chk_addr1) && (chk_addr1 != '0)) chk_busy1 = 1'b1;
         if (vld_q[i] && (fifo_addr_q[i] == chk_addr2) && (chk_addr2 != '0)) chk_busy2 = 1'b1;
      end
   end

   assign we         = we_q;
   assign waddr      = waddr_q;
   assign wdata      = wdata_q;
   assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed cycle checks plus a scoreboard of expected register-file writes.
module tb_wb_write_arbiter;

   logic        clk;
   logic        rst;
   logic        pipe_we;
   logic [4:0]  pipe_waddr;
   logic [31:0] pipe_wdata;
   logic        lsrc_valid;
   logic        lsrc_ready;
   logic [4:0]  lsrc_waddr;
   logic [31:0] lsrc_wdata;
   logic [4:0]  chk_addr1;
   logic [4:0]  chk_addr2;
   logic        chk_busy1;
   logic        chk_busy2;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [2:0]  fifo_count;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t pipe_q[$];
   wr_t lsrc_q[$];
   logic pf_prev;
   int n_checks;
   int n_pass;

   wb_write_arbiter #(.ADDR_W(5), .DATA_W(32), .DEPTH(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst),
      .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
      .lsrc_valid(lsrc_valid), .lsrc_ready(lsrc_ready),
      .lsrc_waddr(lsrc_waddr), .lsrc_wdata(lsrc_wdata),
      .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
      .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
      .we(we), .waddr(waddr), .wdata(wdata), .fifo_count(fifo_count)
   );

   // Decode's WAW obligation is watched on port 2, which always probes the pipeline destination.
   assign chk_addr2 = pipe_waddr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pipe(input logic v, input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      pipe_we    = v;
      pipe_waddr = a;
      pipe_wdata = d;
      if (v && a != 5'd0 && !rst) begin
         e.a = a;
         e.d = d;
         pipe_q.push_back(e);
      end
   endtask

   task automatic offer(input logic v, input logic [4:0] a, input logic [31:0] d);
      lsrc_valid = v;
      lsrc_waddr = a;
      lsrc_wdata = d;
   endtask

   // Acceptance is observed at the edge, so the long-latency queue holds exactly what the DUT took.
   always @(posedge clk) begin
      wr_t e;
      if (rst) begin
         lsrc_q.delete();
         pipe_q.delete();
         pf_prev = 1'b0;
      end else begin
         pf_prev = pipe_we && (pipe_waddr != 5'd0);
         if (lsrc_valid && lsrc_ready && lsrc_waddr != 5'd0) begin
            e.a = lsrc_waddr;
            e.d = lsrc_wdata;
            lsrc_q.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      wr_t e;
      if (!rst && pipe_we && pipe_waddr != 5'd0) check_val("waw_busy", chk_busy2, 0);
      if (we) begin
         if (pf_prev) begin
            check_val("sb_pipe_pending", pipe_q.size() > 0, 1);
            if (pipe_q.size() > 0) begin
               e = pipe_q.pop_front();
               check_val("sb_pipe_addr", waddr, e.a);
               check_val("sb_pipe_data", wdata, e.d);
            end
         end else if (lsrc_q.size() > 0) begin
            e = lsrc_q.pop_front();
            check_val("sb_lsrc_addr", waddr, e.a);
            check_val("sb_lsrc_data", wdata, e.d);
         end else begin
            check_val("spurious_we", we, 0);
         end
      end
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      pf_prev  = 1'b0;
      rst      = 1'b1;
      chk_addr1 = 5'd0;
      drive_pipe(1'b1, 5'd3, 32'h0000_0033);
      offer(1'b1, 5'd4, 32'h0000_0044);

      // Reset held three cycles with activity on both sources.
      for (int k = 0; k < 3; k++) begin
         tick();
         check_val("rst_we", we, 0);
         check_val("rst_waddr", waddr, 0);
         check_val("rst_wdata", wdata, 0);
         check_val("rst_count", fifo_count, 0);
         check_val("rst_ready", lsrc_ready, 0);
      end
      rst = 1'b0;
      drive_pipe(1'b0, 5'd0, 32'd0);
      offer(1'b0, 5'd0, 32'd0);
      #1;
      check_val("ready_after_rst", lsrc_ready, 1);

      // Pipeline write, one-cycle latency.
      drive_pipe(1'b1, 5'd5, 32'hDEAD_BEEF);
      tick();
      check_val("pipe_we", we, 1);
      check_val("pipe_waddr", waddr, 5);
      check_val("pipe_wdata", wdata, 32'hDEAD_BEEF);

      // Register-0 pipeline write produces nothing; address/data hold.
      drive_pipe(1'b1, 5'd0, 32'h1111_1111);
      tick();
      check_val("r0_pipe_we", we, 0);
      check_val("r0_pipe_hold", waddr, 5);
      drive_pipe(1'b0, 5'd0, 32'd0);

      // Single long-latency write with the pipeline idle.
      chk_addr1 = 5'd7;
      offer(1'b1, 5'd7, 32'h1234_5678);
      tick();
      offer(1'b0, 5'd0, 32'd0);
`ifdef WB_BYPASS_EN
      check_val("ll_byp_we", we, 1);
      check_val("ll_byp_waddr", waddr, 7);
      check_val("ll_byp_busy", chk_busy1, 0);
      tick();
      check_val("ll_byp_busy2", chk_busy1, 0);
`else
      check_val("ll_busy_n1", chk_busy1, 1);
      check_val("ll_we_n1", we, 0);
      check_val("ll_count_n1", fifo_count, 1);
      tick();
      check_val("ll_we_n2", we, 1);
      check_val("ll_waddr_n2", waddr, 7);
      check_val("ll_wdata_n2", wdata, 32'h1234_5678);
      check_val("ll_busy_n2", chk_busy1, 0);
      check_val("ll_count_n2", fifo_count, 0);
`endif
      tick();

      // Fill under continuous pipeline writes, then back-pressure a fifth offer.
      for (int k = 0; k < 8; k++) begin
         drive_pipe(1'b1, 5'(k + 1), 32'h100 + k);
         if (k < 4) offer(1'b1, 5'(9 + k), 32'hA0 + k);
         else offer(1'b1, 5'd13, 32'hAD);
         tick();
         check_val("fill_pipe_waddr", waddr, k + 1);
         if (k >= 3) begin
            check_val("fill_count", fifo_count, 4);
            check_val("fill_ready", lsrc_ready, 0);
         end
      end
      drive_pipe(1'b0, 5'd0, 32'd0);
      tick();
      check_val("drain1_waddr", waddr, 9);
      check_val("drain1_count", fifo_count, 3);
      check_val("drain1_ready", lsrc_ready, 1);
      tick();
      offer(1'b0, 5'd0, 32'd0);
      check_val("drain2_waddr", waddr, 10);
      check_val("drain2_count", fifo_count, 3);
      tick();
      check_val("drain3_waddr", waddr, 11);
      tick();
      check_val("drain4_waddr", waddr, 12);
      tick();
      check_val("drain5_waddr", waddr, 13);
      check_val("drain5_wdata", wdata, 32'hAD);
      check_val("drain5_count", fifo_count, 0);
      tick();

      // Register-0 pipeline write does not block a pop in the same cycle.
      drive_pipe(1'b1, 5'd1, 32'h0000_0001);
      offer(1'b1, 5'd15, 32'h0000_00AA);
      tick();
      offer(1'b0, 5'd0, 32'd0);
      drive_pipe(1'b1, 5'd0, 32'h0000_0055);
      tick();
      check_val("r0_pop_we", we, 1);
      check_val("r0_pop_waddr", waddr, 15);
      drive_pipe(1'b0, 5'd0, 32'd0);
      tick();
      check_val("idle_we", we, 0);

      // Long-latency write to register 0 is accepted and dropped.
      offer(1'b1, 5'd0, 32'h0000_0077);
      #1;
      check_val("ll_r0_ready", lsrc_ready, 1);
      tick();
      offer(1'b0, 5'd0, 32'd0);
      check_val("ll_r0_count", fifo_count, 0);
      check_val("ll_r0_we", we, 0);
      tick();
      check_val("ll_r0_we2", we, 0);

      // Reset while three entries are queued.
      chk_addr1 = 5'd20;
      for (int k = 0; k < 3; k++) begin
         drive_pipe(1'b1, 5'(k + 1), 32'h200 + k);
         offer(1'b1, 5'(20 + k), 32'hC0 + k);
         tick();
      end
      offer(1'b0, 5'd0, 32'd0);
      drive_pipe(1'b0, 5'd0, 32'd0);
      check_val("mid_count_pre", fifo_count, 3);
      check_val("mid_busy_pre", chk_busy1, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("mid_count", fifo_count, 0);
      check_val("mid_we", we, 0);
      check_val("mid_busy", chk_busy1, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check_val("mid_no_we", we, 0);
      end

      check_val("sb_pipe_left", pipe_q.size(), 0);
      check_val("sb_lsrc_left", lsrc_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
